mult_share_arbiter: RTL and testbench

Shares one sequential shift-add multiplier among `NUM_REQ` requesters. A round-robin arbiter grants one request at a time and runs the operation over `OPERAND_SIZE` iterations. It then returns the product, tagged with the requester index, on a single response channel with backpressure. The block sits between the multiplier clients and the multiplier datapath and owns all sequencing of that datapath.

---
 rtl/mult_share_pkg.sv | 43 ++++
 rtl/shift_add_core.sv | 70 +++++++
 rtl/mult_share_arbiter.sv | 133 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
//   mult_state_e : top-level sequencing states
//   rr_pick()    : round-robin one-hot grant over up to MAX_REQ requesters
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_e;

    // Upper bound on requesters handled by rr_pick; callers zero-extend
    // their request vector to this width and keep the low NUM_REQ bits.
    localparam int MAX_REQ = 32;
    localparam int IDX_W   = $clog2(MAX_REQ);

    // Returns a one-hot grant for the first set bit of `valid` found when
    // searching upward from last+1, wrapping modulo num_req. All-zero when
    // no bit in the lower num_req positions is set.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [IDX_W-1:0]   last,
        input int                 num_req
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        logic [IDX_W-1:0]   idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= num_req) begin
                idx = IDX_W'((int'(last) + k) % num_req);
                if (!found && valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/shift_add_core.sv
// Sequential unsigned shift-add multiplier, one iteration per cycle.
// Ports:
//   clk, areset_n : clock, asynchronous active-low reset
//   start         : load a/b and begin; ignored while an operation runs
//   a, b          : unsigned operands (multiplicand, multiplier)
//   done          : high in the cycle whose closing edge performs the
//                   final iteration
//   product       : a*b, valid from the edge after done until next start
module shift_add_core #(
    parameter int OPERAND_SIZE = 4
) (
    input  logic                      clk,
    input  logic                      areset_n,
    input  logic                      start,
    input  logic [OPERAND_SIZE-1:0]   a,
    input  logic [OPERAND_SIZE-1:0]   b,
    output logic                      done,
    output logic [2*OPERAND_SIZE-1:0] product
);

    localparam int ACC_W = 2 * OPERAND_SIZE + 1;
    // Wide enough to hold OPERAND_SIZE itself, the terminal count.
    localparam int CNT_W = $clog2(OPERAND_SIZE + 1);

    logic [OPERAND_SIZE-1:0] a_q;
    logic [ACC_W-1:0]        acc;      // {carry, hi, lo}
    logic [ACC_W-1:0]        acc_step;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    running;

    // NOTE: every variable assigned in always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_step = acc >> 1;
        if (acc[0]) begin
            // hi + a fits in {carry, hi}; the shift then drops the used lo bit.
            acc_step = (acc + {1'b0, a_q, {OPERAND_SIZE{1'b0}}}) >> 1;
        end
        cnt_inc = cnt + 1'b1;
    end

    assign done    = running && (cnt_inc == CNT_W'(OPERAND_SIZE));
    assign product = acc[2*OPERAND_SIZE-1:0];

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    // All datapath registers are reset so an aborted operation leaves no
    // stale product visible.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            a_q     <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start && !running) begin
            a_q     <= a;
            acc     <= {1'b0, {OPERAND_SIZE{1'b0}}, b};
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc     <= acc_step;
            cnt     <= cnt_inc;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one shift_add_core among NUM_REQ requesters with round-robin
// arbitration and a single tagged response channel with backpressure.
// Ports:
//   clk, areset_n : clock, asynchronous active-low reset
//   req_valid     : per-requester operation pending
//   req_ready     : one-hot grant, only in IDLE
//   req_a, req_b  : packed operands, requester i at [i*OPERAND_SIZE +: OPERAND_SIZE]
//   rsp_valid     : product/tag valid (DONE state)
//   rsp_ready     : consumer accepts response
//   rsp_id        : requester index owning the product
//   rsp_product   : unsigned a*b
//   busy          : high outside IDLE
module mult_share_arbiter #(
    parameter int OPERAND_SIZE = 4,
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              areset_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*OPERAND_SIZE-1:0]   req_a,
    input  logic [NUM_REQ*OPERAND_SIZE-1:0]   req_b,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [ID_W-1:0]                   rsp_id,
    output logic [2*OPERAND_SIZE-1:0]         rsp_product,
    output logic                              busy
);

    import mult_share_pkg::*;

    mult_state_e state;
    mult_state_e state_next;

    logic [ID_W-1:0]             last_grant;
    logic [ID_W-1:0]             tag_q;
    logic [ID_W-1:0]             win_id;
    logic [MAX_REQ-1:0]          grant_full;
    logic [NUM_REQ-1:0]          grant;
    logic                        accept;
    logic [OPERAND_SIZE-1:0]     core_a;
    logic [OPERAND_SIZE-1:0]     core_b;
    logic                        core_done;
    logic [2*OPERAND_SIZE-1:0]   core_product;

    // Winner depends only on req_valid and last_grant, never on rsp_ready.
    assign grant_full = rr_pick(MAX_REQ'(req_valid), IDX_W'(last_grant), NUM_REQ);
    assign grant      = grant_full[NUM_REQ-1:0];

    if (NUM_REQ < MAX_REQ) begin : g_pad
        logic unused_grant_bits;
        assign unused_grant_bits = ^grant_full[MAX_REQ-1:NUM_REQ];
    end

    always_comb begin
        win_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    // grant is a subset of req_valid, so any grant bit in IDLE is a handshake.
    assign accept = (state == IDLE) && (|grant);
    assign core_a = req_a[int'(win_id) * OPERAND_SIZE +: OPERAND_SIZE];
    assign core_b = req_b[int'(win_id) * OPERAND_SIZE +: OPERAND_SIZE];

    shift_add_core #(
        .OPERAND_SIZE (OPERAND_SIZE)
    ) u_core (
        .clk      (clk),
        .areset_n (areset_n),
        .start    (accept),
        .a        (core_a),
        .b        (core_b),
        .done     (core_done),
        .product  (core_product)
    );

    // State register
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (core_done) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready   = '0;
        busy        = 1'b0;
        rsp_valid   = 1'b0;
        rsp_product = '0;
        case (state)
            IDLE: req_ready = grant;
            RUN:  busy      = 1'b1;
            DONE: begin
                busy        = 1'b1;
                rsp_valid   = 1'b1;
                rsp_product = core_product;
            end
            default: ;
        endcase
    end

    // Priority pointer and response tag move only on an accepted request.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            tag_q      <= '0;
        end else if (accept) begin
            last_grant <= win_id;
            tag_q      <= win_id;
        end
    end

    assign rsp_id = tag_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

    localparam int OPS = 4;
    localparam int NR  = 4;

    logic        clk = 1'b0;
    logic        areset_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_product;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    mult_share_arbiter #(
        .OPERAND_SIZE (OPS),
        .NUM_REQ      (NR)
    ) dut (
        .clk         (clk),
        .areset_n    (areset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first valid index after `last`, wrapping.
    function automatic int tb_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (last + k) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Behavioural model: 0 = waiting for a grant, 1 = computing
    // (OPS cycles), 2 = product on offer until accepted.
    int m_phase = 0;
    int m_cnt   = 0;
    int m_last  = NR - 1;
    int m_id    = 0;
    int m_prod  = 0;
    int cyc     = 0;
    int g_id_q[$];
    int g_cyc_q[$];

    always @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            m_phase = 0;
            m_cnt   = 0;
            m_last  = NR - 1;
        end else begin
            cyc++;
            case (m_phase)
                0: begin
                    int w;
                    w = tb_pick(req_valid, m_last);
                    if (w >= 0) begin
                        m_last  = w;
                        m_id    = w;
                        m_prod  = int'(req_a[w*4 +: 4]) * int'(req_b[w*4 +: 4]);
                        m_cnt   = OPS;
                        m_phase = 1;
                        g_id_q.push_back(w);
                        g_cyc_q.push_back(cyc);
                    end
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_phase = 2;
                end
                default: begin
                    if (rsp_ready) m_phase = 0;
                end
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en && areset_n) begin
            int p;
            logic [31:0] exp_ready;
            p = tb_pick(req_valid, m_last);
            exp_ready = (m_phase == 0 && p >= 0) ? (32'd1 << p) : 32'd0;
            check("req_ready", 32'(req_ready), exp_ready);
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
            if (m_phase == 2) begin
                check("rsp_product", 32'(rsp_product), 32'(m_prod));
                check("rsp_id", 32'(rsp_id), 32'(m_id));
            end
        end
    end

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*4 +: 4] = 4'(a);
        req_b[i*4 +: 4] = 4'(b);
        req_valid[i]    = 1'b1;
    endtask

    task automatic await_handshake(input int i, output int hs, output logic [3:0] seen);
        int n;
        n = 0;
        @(negedge clk);
        while (!(req_valid[i] && req_ready[i]) && n < 40) begin
            @(negedge clk);
            n++;
        end
        seen = req_ready;
        check($sformatf("handshake_seen_%0d", i), 32'(req_valid[i] & req_ready[i]), 1);
        @(posedge clk);
        #1;
        hs = cyc;
        req_valid[i] = 1'b0;
    endtask

    task automatic await_rsp(output int id, output int prod, output int rise);
        int n;
        n = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rsp_seen", 32'(rsp_valid), 1);
        id   = int'(rsp_id);
        prod = int'(rsp_product);
        rise = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (busy && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_reached", 32'(busy), 0);
    endtask

    int s2_id[3]   = '{0, 1, 3};
    int s2_a[3]    = '{15, 0, 7};
    int s2_b[3]    = '{15, 9, 1};
    int s2_exp[3]  = '{225, 0, 7};
    int s3_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int hs, rise, id, prod, base, r_edge, n;
        logic [3:0] seen;

        // Reset values
        #1 areset_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_product", 32'(rsp_product), 0);
        #10 areset_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // 1: single requester, latency
        set_op(2, 13, 11);
        await_handshake(2, hs, seen);
        check("s1_ready_onehot", 32'(seen), 32'h4);
        await_rsp(id, prod, rise);
        check("s1_id", 32'(id), 2);
        check("s1_product", 32'(prod), 143);
        check("s1_latency", 32'(rise - hs), OPS);
        @(posedge clk);
        #1;
        check("s1_rsp_consumed", 32'(rsp_valid), 0);

        // 2: boundary operands
        for (int i = 0; i < 3; i++) begin
            set_op(s2_id[i], s2_a[i], s2_b[i]);
            await_handshake(s2_id[i], hs, seen);
            await_rsp(id, prod, rise);
            check($sformatf("s2_product_%0d", i), 32'(prod), 32'(s2_exp[i]));
            check($sformatf("s2_id_%0d", i), 32'(id), 32'(s2_id[i]));
            @(posedge clk);
            #1;
        end

        // 3: all requesters continuously valid
        base = g_id_q.size();
        set_op(0, 1, 2);
        set_op(1, 3, 4);
        set_op(2, 5, 6);
        set_op(3, 7, 8);
        n = 0;
        while (g_id_q.size() < base + 5 && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = '0;
        check("s3_grant_count", 32'(g_id_q.size() - base), 5);
        for (int i = 0; i < 5; i++) begin
            if (g_id_q.size() > base + i) begin
                check($sformatf("s3_order_%0d", i), 32'(g_id_q[base+i]), 32'(s3_order[i]));
                if (i > 0)
                    check($sformatf("s3_interval_%0d", i),
                          32'(g_cyc_q[base+i] - g_cyc_q[base+i-1]), OPS + 2);
            end
        end
        wait_idle();

        // 4: backpressure in DONE with another request pending
        rsp_ready = 1'b0;
        set_op(1, 6, 5);
        await_handshake(1, hs, seen);
        set_op(3, 2, 2);
        await_rsp(id, prod, rise);
        check("s4_product", 32'(prod), 30);
        check("s4_id", 32'(id), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("s4_hold_product", 32'(rsp_product), 30);
            check("s4_hold_id", 32'(rsp_id), 1);
            check("s4_hold_valid", 32'(rsp_valid), 1);
            check("s4_hold_ready", 32'(req_ready), 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        r_edge = cyc;
        check("s4_rsp_done", 32'(rsp_valid), 0);
        await_handshake(3, hs, seen);
        check("s4_next_grant_gap", 32'(hs - r_edge), 1);
        check("s4_next_grant_ready", 32'(seen), 32'h8);
        await_rsp(id, prod, rise);
        check("s4_second_product", 32'(prod), 4);
        @(posedge clk);
        #1;

        // 5: reset during the second RUN cycle
        set_op(2, 3, 3);
        await_handshake(2, hs, seen);
        @(posedge clk);
        #2 areset_n = 1'b0;
        #1;
        check("s5_busy", 32'(busy), 0);
        check("s5_rsp_valid", 32'(rsp_valid), 0);
        check("s5_req_ready", 32'(req_ready), 0);
        check("s5_rsp_product", 32'(rsp_product), 0);
        check("s5_rsp_id", 32'(rsp_id), 0);
        #10 areset_n = 1'b1;
        @(posedge clk);
        #1;
        base = g_id_q.size();
        set_op(0, 9, 9);
        set_op(1, 1, 1);
        set_op(2, 2, 2);
        set_op(3, 3, 3);
        await_handshake(0, hs, seen);
        req_valid = '0;
        check("s5_first_grant", 32'(seen), 32'h1);
        if (g_id_q.size() > base)
            check("s5_model_grant", 32'(g_id_q[base]), 0);
        await_rsp(id, prod, rise);
        check("s5_product", 32'(prod), 81);
        check("s5_id", 32'(id), 0);
        @(posedge clk);
        #1;

        // 6: transient request during RUN is not recorded
        set_op(3, 2, 3);
        await_handshake(3, hs, seen);
        base = g_id_q.size();
        @(posedge clk);
        #1 set_op(1, 5, 5);
        @(posedge clk);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        await_rsp(id, prod, rise);
        check("s6_product", 32'(prod), 6);
        check("s6_id", 32'(id), 3);
        repeat (3) @(posedge clk);
        #1;
        check("s6_no_extra_grant", 32'(g_id_q.size()), 32'(base));
        check("s6_idle", 32'(busy), 0);
        set_op(0, 4, 4);
        set_op(2, 5, 5);
        await_handshake(0, hs, seen);
        check("s6_pointer_kept", 32'(seen), 32'h1);
        await_rsp(id, prod, rise);
        check("s6_product_0", 32'(prod), 16);
        await_handshake(2, hs, seen);
        await_rsp(id, prod, rise);
        check("s6_product_2", 32'(prod), 25);
        check("s6_id_2", 32'(id), 2);
        wait_idle();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish by %0t", $time);
        $fatal(1);
    end

endmodule
